// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES vector sequencer: FSM states,
// the FIPS-197 AES-128 example vector and a saturating increment helper.
package aes_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_GAP,
        S_DONE
    } seq_state_t;

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    // Holds at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = 32'hFFFF_FFFF >> (32 - w);
        return (v == max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/aes_vector_mem.sv
// Vector table: DEPTH entries of {pt, key, ct}, one write port and a
// combinational read port.
module aes_vector_mem #(
    parameter int DEPTH  = 4,
    parameter int ENT_W  = 384,
    parameter int ADDR_W = 2
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [ENT_W-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [ENT_W-1:0]  o_rd_data
);

    logic [ENT_W-1:0] r_mem [DEPTH];

    // Address decode by loop so out-of-range addresses simply miss.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (i_wr_en && i_wr_addr == ADDR_W'(i)) r_mem[i] <= i_wr_data;
        end
    end

    always_comb begin
        o_rd_data = r_mem[0];
        for (int i = 1; i < DEPTH; i++) begin
            if (i_rd_addr == ADDR_W'(i)) o_rd_data = r_mem[i];
        end
    end

endmodule

// File: rtl/aes_vector_sequencer.sv
// Drives a table of AES test vectors into AES_top one at a time, waits for
// the result or a timeout, and keeps saturating pass/fail/timeout statistics.
module aes_vector_sequencer
    import aes_seq_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int KEY_W   = 128,
    parameter int NUM_VEC = 4,
    parameter int IDX_W   = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64,
    parameter int GAP     = 2
) (
    input  logic              AES_clk,
    input  logic              AES_rst,
    input  logic              start,
    input  logic              abort,
    input  logic              cfg_loop,
    input  logic              vec_wr_en,
    input  logic [IDX_W-1:0]  vec_wr_addr,
    input  logic [DATA_W-1:0] vec_wr_pt,
    input  logic [KEY_W-1:0]  vec_wr_key,
    input  logic [DATA_W-1:0] vec_wr_ct,
    output logic              dut_en,
    output logic [DATA_W-1:0] dut_data,
    output logic [KEY_W-1:0]  dut_key,
    input  logic              dut_valid,
    input  logic [DATA_W-1:0] dut_data_out,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CNT_W-1:0]  timeout_cnt,
    output logic              first_fail_vld,
    output logic [IDX_W-1:0]  first_fail_idx
);

    localparam int ENT_W  = 2 * DATA_W + KEY_W;
    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_VEC - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP - 1);

    seq_state_t        r_state, w_next;
    logic [IDX_W-1:0]  r_idx;
    logic [WAIT_W-1:0] r_wait;
    logic [GAP_W-1:0]  r_gap;
    logic [DATA_W-1:0] r_dut_data;
    logic [KEY_W-1:0]  r_dut_key;
    logic [CNT_W-1:0]  r_pass_cnt, r_fail_cnt, r_to_cnt;
    logic              r_ff_vld;
    logic [IDX_W-1:0]  r_ff_idx;

    logic [ENT_W-1:0]  w_entry;
    logic [DATA_W-1:0] w_pt, w_ct;
    logic [KEY_W-1:0]  w_key;
    logic              w_wr_en, w_begin, w_pass, w_fail, w_to, w_gap_end;
    logic              w_dut_en, w_done, w_busy;

    assign w_wr_en = vec_wr_en && (r_state == S_IDLE);

    aes_vector_mem #(
        .DEPTH (NUM_VEC),
        .ENT_W (ENT_W),
        .ADDR_W(IDX_W)
    ) u_mem (
        .i_clk    (AES_clk),
        .i_wr_en  (w_wr_en),
        .i_wr_addr(vec_wr_addr),
        .i_wr_data({vec_wr_pt, vec_wr_key, vec_wr_ct}),
        .i_rd_addr(r_idx),
        .o_rd_data(w_entry)
    );

    assign {w_pt, w_key, w_ct} = w_entry;

    always_comb begin
        w_next    = r_state;
        w_begin   = 1'b0;
        w_pass    = 1'b0;
        w_fail    = 1'b0;
        w_to      = 1'b0;
        w_gap_end = 1'b0;
        w_dut_en  = 1'b0;
        w_done    = 1'b0;
        w_busy    = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next  = S_LOAD;
                    w_begin = 1'b1;
                end
            end
            S_LOAD: w_next = S_RUN;
            S_RUN: begin
                w_dut_en = 1'b1;
                // A result on the last permitted cycle still counts as a compare.
                if (dut_valid) begin
                    w_pass = (dut_data_out == w_ct);
                    w_fail = (dut_data_out != w_ct);
                    w_next = S_GAP;
                end else if (r_wait == WAIT_LAST) begin
                    w_to   = 1'b1;
                    w_next = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_gap_end = 1'b1;
                    w_next    = (r_idx != LAST_IDX || cfg_loop) ? S_LOAD : S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (abort) begin
            w_next    = S_IDLE;
            w_begin   = 1'b0;
            w_pass    = 1'b0;
            w_fail    = 1'b0;
            w_to      = 1'b0;
            w_gap_end = 1'b0;
        end
    end

    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            r_idx      <= '0;
            r_wait     <= '0;
            r_gap      <= '0;
            r_dut_data <= '0;
            r_dut_key  <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_to_cnt   <= '0;
            r_ff_vld   <= 1'b0;
            r_ff_idx   <= '0;
        end else begin
            r_wait <= (r_state == S_RUN) ? r_wait + 1'b1 : '0;
            r_gap  <= (r_state == S_GAP) ? r_gap + 1'b1 : '0;
            if (w_begin) begin
                r_idx      <= '0;
                r_pass_cnt <= '0;
                r_fail_cnt <= '0;
                r_to_cnt   <= '0;
                r_ff_vld   <= 1'b0;
                r_ff_idx   <= '0;
            end
            if (r_state == S_LOAD) begin
                r_dut_data <= w_pt;
                r_dut_key  <= w_key;
            end
            if (w_gap_end) begin
                if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
                else if (cfg_loop)     r_idx <= '0;
            end
            if (w_pass) r_pass_cnt <= CNT_W'(sat_inc(32'(r_pass_cnt), CNT_W));
            if (w_fail) r_fail_cnt <= CNT_W'(sat_inc(32'(r_fail_cnt), CNT_W));
            if (w_to)   r_to_cnt   <= CNT_W'(sat_inc(32'(r_to_cnt), CNT_W));
            if ((w_fail || w_to) && !r_ff_vld) begin
                r_ff_vld <= 1'b1;
                r_ff_idx <= r_idx;
            end
        end
    end

    assign dut_en         = w_dut_en;
    assign dut_data       = r_dut_data;
    assign dut_key        = r_dut_key;
    assign busy           = w_busy;
    assign done           = w_done;
    assign pass_cnt       = r_pass_cnt;
    assign fail_cnt       = r_fail_cnt;
    assign timeout_cnt    = r_to_cnt;
    assign first_fail_vld = r_ff_vld;
    assign first_fail_idx = r_ff_idx;

endmodule
